score_tally: RTL and testbench



---
 rtl/score_tally_if.sv | 30 +++
 rtl/score_tally.sv | 162 ++++++++++++++++
 tb/tb_score_tally.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_tally_if.sv
// Note-event inputs and game-statistic outputs of score_tally, grouped as one bundle.
// master = the side that drives keycode and the note levels; slave = score_tally.
interface score_tally_if #(
  parameter int unsigned N_NOTES = 48,
  parameter int unsigned SCORE_W = 16
);
  logic [7:0]         keycode;
  logic [N_NOTES-1:0] hit_lvl;
  logic [N_NOTES-1:0] miss_lvl;
  logic [SCORE_W-1:0] score_total;
  logic [7:0]         combo;
  logic [7:0]         max_combo;
  logic [7:0]         hit_count;
  logic [7:0]         miss_count;
  logic               game_active;
  logic               round_done;
  logic               hit_pulse;

  modport master (
    output keycode, hit_lvl, miss_lvl,
    input  score_total, combo, max_combo, hit_count, miss_count,
    input  game_active, round_done, hit_pulse
  );

  modport slave (
    input  keycode, hit_lvl, miss_lvl,
    output score_total, combo, max_combo, hit_count, miss_count,
    output game_active, round_done, hit_pulse
  );
endinterface

// File: rtl/score_tally.sv
// Turns per-note hit/miss levels into score, combo and hit/miss statistics for one round.
// Optional macro SCORE_TALLY_COMBO_BONUS_EN: hits at combo >= BONUS_THRESH earn BONUS_PTS extra.
module score_tally #(
  parameter int unsigned N_NOTES      = 48,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned POINTS       = 10,
  parameter int unsigned BONUS_THRESH = 10,
  parameter int unsigned BONUS_PTS    = 5
) (
  input logic          frame_clk,
  input logic          Reset,
  score_tally_if.slave bus
);
  localparam int unsigned CntW  = $clog2(N_NOTES + 1);
  localparam int unsigned SumW  = ((CntW > 8) ? CntW : 8) + 1;
  localparam int unsigned ProdW = SCORE_W + 8;
  localparam logic [7:0]  KeyStart = 8'h2C;
  localparam logic [7:0]  KeyIdle  = 8'h01;
  localparam logic [ProdW:0] ScoreMax = {{(ProdW + 1 - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

`ifdef SCORE_TALLY_COMBO_BONUS_EN
  localparam bit BonusEn = 1'b1;
`else
  localparam bit BonusEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_NOTES-1:0] hit_prev_q, miss_prev_q;
  logic [N_NOTES-1:0] hit_edge, miss_edge;
  logic [CntW-1:0]    new_hits, new_misses;
  logic [SCORE_W-1:0] score_q, score_d, score_nxt;
  logic [7:0]         combo_q, combo_d, combo_nxt;
  logic [7:0]         max_combo_q, max_combo_d, max_combo_nxt;
  logic [7:0]         hit_count_q, hit_count_d, hit_count_nxt;
  logic [7:0]         miss_count_q, miss_count_d, miss_count_nxt;
  logic               hit_pulse_q, hit_pulse_d;
  logic               bonus_hit;
  logic [ProdW-1:0]   pts_per_hit, hit_points;
  logic [ProdW:0]     score_sum;
  logic [8:0]         resolved;

  function automatic logic [CntW-1:0] popcount(input logic [N_NOTES-1:0] v);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_NOTES; i++) begin
      cnt = cnt + CntW'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CntW-1:0] b);
    logic [SumW-1:0] s;
    s = SumW'(a) + SumW'(b);
    return (s > SumW'(255)) ? 8'hFF : s[7:0];
  endfunction

  // A note whose hit and miss both rise in the same cycle counts as a hit only.
  assign hit_edge   = bus.hit_lvl & ~hit_prev_q;
  assign miss_edge  = bus.miss_lvl & ~miss_prev_q & ~hit_edge;
  assign new_hits   = popcount(hit_edge);
  assign new_misses = popcount(miss_edge);

  always_comb begin
    combo_nxt      = (new_misses != '0) ? sat_add8(8'd0, new_hits) : sat_add8(combo_q, new_hits);
    max_combo_nxt  = (combo_nxt > max_combo_q) ? combo_nxt : max_combo_q;
    hit_count_nxt  = sat_add8(hit_count_q, new_hits);
    miss_count_nxt = sat_add8(miss_count_q, new_misses);
    resolved       = {1'b0, hit_count_nxt} + {1'b0, miss_count_nxt};

    // Bonus is judged once per cycle against the already-updated combo.
    bonus_hit   = BonusEn && (32'(combo_nxt) >= BONUS_THRESH);
    pts_per_hit = ProdW'(POINTS) + (bonus_hit ? ProdW'(BONUS_PTS) : '0);
    hit_points  = ProdW'(new_hits) * pts_per_hit;
    score_sum   = {1'b0, ProdW'(score_q)} + {1'b0, hit_points};
    score_nxt   = (score_sum > ScoreMax) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    combo_d      = combo_q;
    max_combo_d  = max_combo_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    hit_pulse_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        score_d      = '0;
        combo_d      = '0;
        max_combo_d  = '0;
        hit_count_d  = '0;
        miss_count_d = '0;
        if (bus.keycode == KeyStart) state_d = StPlay;
      end
      StPlay: begin
        if (bus.keycode == KeyIdle) begin
          state_d      = StIdle;
          score_d      = '0;
          combo_d      = '0;
          max_combo_d  = '0;
          hit_count_d  = '0;
          miss_count_d = '0;
        end else begin
          score_d      = score_nxt;
          combo_d      = combo_nxt;
          max_combo_d  = max_combo_nxt;
          hit_count_d  = hit_count_nxt;
          miss_count_d = miss_count_nxt;
          hit_pulse_d  = (new_hits != '0);
          if (32'(resolved) >= N_NOTES) state_d = StDone;
        end
      end
      StDone: begin
        if (bus.keycode == KeyIdle) begin
          state_d      = StIdle;
          score_d      = '0;
          combo_d      = '0;
          max_combo_d  = '0;
          hit_count_d  = '0;
          miss_count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      hit_prev_q   <= '0;
      miss_prev_q  <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      max_combo_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      hit_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_prev_q   <= bus.hit_lvl;
      miss_prev_q  <= bus.miss_lvl;
      score_q      <= score_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      hit_pulse_q  <= hit_pulse_d;
    end
  end

  assign bus.score_total = score_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_combo_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;
  assign bus.game_active = (state_q == StPlay);
  assign bus.round_done  = (state_q == StDone);
  assign bus.hit_pulse   = hit_pulse_q;
endmodule

// File: tb/tb_score_tally.sv
// Bench for score_tally: a 48-note instance and a 4-note instance with an 8-bit score,
// both checked against a behavioural model of the game rules.
module tb_score_tally;
`ifdef SCORE_TALLY_COMBO_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  typedef struct {
    int          st;      // 0 idle, 1 play, 2 done
    longint      score;
    int          combo;
    int          maxc;
    int          hc;
    int          mc;
    bit          pulse;
    logic [47:0] hp;
    logic [47:0] mp;
  } model_t;

  logic   frame_clk = 1'b0;
  logic   Reset = 1'b1;
  int     n_tests = 0;
  int     n_fail = 0;
  model_t ma, mb;

  score_tally_if #(.N_NOTES(48), .SCORE_W(16)) ifa ();
  score_tally_if #(.N_NOTES(4), .SCORE_W(8)) ifb ();

  score_tally #(.N_NOTES(48), .SCORE_W(16), .POINTS(10), .BONUS_THRESH(10), .BONUS_PTS(5))
    dut_a (.frame_clk(frame_clk), .Reset(Reset), .bus(ifa.slave));
  score_tally #(.N_NOTES(4), .SCORE_W(8), .POINTS(100), .BONUS_THRESH(10), .BONUS_PTS(5))
    dut_b (.frame_clk(frame_clk), .Reset(Reset), .bus(ifb.slave));

  always #5 frame_clk = ~frame_clk;

  function automatic model_t model_step(model_t m, int n, int sw, int pts, logic rst,
                                        logic [7:0] key, logic [47:0] hit, logic [47:0] miss);
    model_t      r;
    logic [47:0] he, me;
    int          nh, nm, pp;
    longint      smax;
    r     = m;
    smax  = (longint'(1) << sw) - 1;
    he    = hit & ~m.hp;
    me    = miss & ~m.mp & ~he;
    nh    = $countones(he);
    nm    = $countones(me);
    r.pulse = 1'b0;
    if (rst || (m.st == 0) || (m.st != 0 && key == 8'h01)) begin
      r.score = 0; r.combo = 0; r.maxc = 0; r.hc = 0; r.mc = 0;
    end
    if (rst) begin
      r.st = 0; r.hp = '0; r.mp = '0;
      return r;
    end
    if (m.st == 0) begin
      if (key == 8'h2C) r.st = 1;
    end else if (key == 8'h01) begin
      r.st = 0;
    end else if (m.st == 1) begin
      r.combo = (nm > 0) ? nh : m.combo + nh;
      if (r.combo > 255) r.combo = 255;
      if (r.combo > r.maxc) r.maxc = r.combo;
      pp = pts + ((BONUS && r.combo >= 10) ? 5 : 0);
      r.score = m.score + longint'(nh) * pp;
      if (r.score > smax) r.score = smax;
      r.hc = (m.hc + nh > 255) ? 255 : m.hc + nh;
      r.mc = (m.mc + nm > 255) ? 255 : m.mc + nm;
      r.pulse = (nh > 0);
      if (r.hc + r.mc >= n) r.st = 2;
    end
    r.hp = hit;
    r.mp = miss;
    return r;
  endfunction

  always @(posedge frame_clk) begin
    ma = model_step(ma, 48, 16, 10, Reset, ifa.keycode, ifa.hit_lvl, ifa.miss_lvl);
    mb = model_step(mb, 4, 8, 100, Reset, ifb.keycode, {44'd0, ifb.hit_lvl}, {44'd0, ifb.miss_lvl});
  end

  function automatic logic [50:0] pack_m(model_t m);
    return {16'(m.score), 8'(m.combo), 8'(m.maxc), 8'(m.hc), 8'(m.mc),
            m.st == 1, m.st == 2, m.pulse};
  endfunction

  function automatic logic [50:0] vec(int s, int c, int mx, int h, int ms, bit ga, bit rd, bit p);
    return {16'(s), 8'(c), 8'(mx), 8'(h), 8'(ms), ga, rd, p};
  endfunction

  function automatic logic [50:0] obs_a();
    return {ifa.score_total, ifa.combo, ifa.max_combo, ifa.hit_count, ifa.miss_count,
            ifa.game_active, ifa.round_done, ifa.hit_pulse};
  endfunction

  function automatic logic [50:0] obs_b();
    return {8'd0, ifb.score_total, ifb.combo, ifb.max_combo, ifb.hit_count, ifb.miss_count,
            ifb.game_active, ifb.round_done, ifb.hit_pulse};
  endfunction

  task automatic idle_a();
    ifa.keycode = 8'h01; ifa.hit_lvl = '0; ifa.miss_lvl = '0;
    @(negedge frame_clk);
    ifa.keycode = 8'h00;
  endtask

  task automatic start_a();
    ifa.keycode = 8'h2C;
    @(negedge frame_clk);
    ifa.keycode = 8'h00;
  endtask

  task automatic test_reset();
    ifa.keycode = 8'h00; ifa.hit_lvl = '0; ifa.miss_lvl = '0;
    ifb.keycode = 8'h00; ifb.hit_lvl = '0; ifb.miss_lvl = '0;
    Reset = 1'b1;
    repeat (2) @(negedge frame_clk);
    Reset = 1'b0;
    n_tests++;
    if (obs_a() !== vec(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_a: got %h want %h", obs_a(), vec(0, 0, 0, 0, 0, 0, 0, 0));
    end
    n_tests++;
    if (obs_b() !== vec(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_b: got %h want %h", obs_b(), vec(0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_start_and_hits();
    int pulses = 0;
    logic [50:0] want [4];
    want[0] = vec(10, 1, 1, 1, 0, 1, 0, 1);
    want[1] = vec(10, 1, 1, 1, 0, 1, 0, 0);
    want[2] = vec(20, 2, 2, 2, 0, 1, 0, 1);
    want[3] = vec(20, 2, 2, 2, 0, 1, 0, 0);
    start_a();
    n_tests++;
    if (obs_a() !== vec(0, 0, 0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL start: got %h want %h", obs_a(), vec(0, 0, 0, 0, 0, 1, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) ifa.hit_lvl[3] = 1'b1;
      if (i == 2) ifa.hit_lvl[7] = 1'b1;
      @(negedge frame_clk);
      pulses += int'(ifa.hit_pulse);
      n_tests++;
      if (obs_a() !== want[i]) begin
        n_fail++; $display("FAIL hits_step%0d: got %h want %h", i, obs_a(), want[i]);
      end
    end
    n_tests++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL hit_pulse_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_same_cycle();
    ifa.miss_lvl[5] = 1'b1; ifa.hit_lvl[9] = 1'b1;
    @(negedge frame_clk);
    n_tests++;
    if (obs_a() !== vec(30, 1, 2, 3, 1, 1, 0, 1)) begin
      n_fail++; $display("FAIL miss_and_hit: got %h want %h", obs_a(), vec(30, 1, 2, 3, 1, 1, 0, 1));
    end
    ifa.miss_lvl[11] = 1'b1; ifa.hit_lvl[11] = 1'b1;
    @(negedge frame_clk);
    n_tests++;
    if (obs_a() !== vec(40, 2, 2, 4, 1, 1, 0, 1)) begin
      n_fail++; $display("FAIL same_note: got %h want %h", obs_a(), vec(40, 2, 2, 4, 1, 1, 0, 1));
    end
  endtask

  task automatic test_stale_levels();
    idle_a();
    ifa.hit_lvl[0] = 1'b1;
    @(negedge frame_clk);
    start_a();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs_a() !== vec(0, 0, 0, 0, 0, 1, 0, 0)) begin
        n_fail++; $display("FAIL stale_%0d: got %h want %h", i, obs_a(), vec(0, 0, 0, 0, 0, 1, 0, 0));
      end
      @(negedge frame_clk);
    end
    ifa.hit_lvl[1] = 1'b1;
    @(negedge frame_clk);
    n_tests++;
    if (obs_a() !== vec(10, 1, 1, 1, 0, 1, 0, 1)) begin
      n_fail++; $display("FAIL first_real_edge: got %h want %h", obs_a(), vec(10, 1, 1, 1, 0, 1, 0, 1));
    end
    ifa.hit_lvl[1] = 1'b0;
    @(negedge frame_clk);
    ifa.hit_lvl[1] = 1'b1;
    @(negedge frame_clk);
    n_tests++;
    if (obs_a() !== vec(20, 2, 2, 2, 0, 1, 0, 1)) begin
      n_fail++; $display("FAIL re_rise: got %h want %h", obs_a(), vec(20, 2, 2, 2, 0, 1, 0, 1));
    end
  endtask

  task automatic test_back_to_back();
    int want_score;
    want_score = BONUS ? 135 : 120;
    idle_a();
    start_a();
    for (int i = 0; i < 12; i++) begin
      ifa.hit_lvl[i] = 1'b1;
      @(negedge frame_clk);
      n_tests++;
      if (obs_a() !== pack_m(ma)) begin
        n_fail++; $display("FAIL b2b_hit%0d: got %h want %h", i, obs_a(), pack_m(ma));
      end
    end
    n_tests++;
    if (obs_a() !== vec(want_score, 12, 12, 12, 0, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL b2b_total: got %h want %h", obs_a(), vec(want_score, 12, 12, 12, 0, 1, 0, 1));
    end
  endtask

  task automatic test_reset_mid_play();
    idle_a();
    start_a();
    for (int i = 0; i < 5; i++) begin
      ifa.hit_lvl[20 + i] = 1'b1;
      @(negedge frame_clk);
    end
    n_tests++;
    if (ifa.score_total !== 16'd50) begin
      n_fail++; $display("FAIL pre_reset_score: got %0d want 50", ifa.score_total);
    end
    Reset = 1'b1;
    @(negedge frame_clk);
    Reset = 1'b0;
    n_tests++;
    if (obs_a() !== vec(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL mid_reset: got %h want %h", obs_a(), vec(0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge frame_clk);
    n_tests++;
    if (obs_a() !== vec(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want %h", obs_a(), vec(0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_done();
    logic [50:0] want [9];
    // 8-bit score with 100 points per hit saturates on the third hit.
    want[0] = vec(0, 0, 0, 0, 0, 1, 0, 0);
    want[1] = vec(100, 1, 1, 1, 0, 1, 0, 1);
    want[2] = vec(200, 2, 2, 2, 0, 1, 0, 1);
    want[3] = vec(255, 3, 3, 3, 0, 1, 0, 1);
    want[4] = vec(255, 0, 3, 3, 1, 0, 1, 0);
    want[5] = want[4];
    want[6] = want[4];
    want[7] = want[4];
    want[8] = vec(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      ifb.keycode = 8'h00;
      case (i)
        0: ifb.keycode = 8'h2C;
        1, 2, 3: ifb.hit_lvl[i-1] = 1'b1;
        4: ifb.miss_lvl[3] = 1'b1;
        5: ifb.hit_lvl[0] = 1'b0;
        6: begin ifb.hit_lvl[0] = 1'b1; ifb.miss_lvl[1] = 1'b1; end
        7: ifb.keycode = 8'h2C;
        default: ifb.keycode = 8'h01;
      endcase
      @(negedge frame_clk);
      n_tests++;
      if (obs_b() !== want[i]) begin
        n_fail++; $display("FAIL done_step%0d: got %h want %h", i, obs_b(), want[i]);
      end
      n_tests++;
      if (obs_b() !== pack_m(mb)) begin
        n_fail++; $display("FAIL done_model%0d: got %h want %h", i, obs_b(), pack_m(mb));
      end
    end
    ifb.keycode = 8'h00;
  endtask

  task automatic test_random();
    int r;
    idle_a();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) ifa.keycode = 8'h01;
      else if (r < 8) ifa.keycode = 8'h2C;
      else ifa.keycode = 8'($urandom_range(2, 43));
      if ($urandom_range(0, 2) == 0) ifa.hit_lvl[$urandom_range(0, 47)] = 1'b1;
      if ($urandom_range(0, 4) == 0) ifa.miss_lvl[$urandom_range(0, 47)] = 1'b1;
      if ($urandom_range(0, 9) == 0) ifa.hit_lvl[$urandom_range(0, 47)] = 1'b0;
      if ($urandom_range(0, 11) == 0) ifa.miss_lvl[$urandom_range(0, 47)] = 1'b0;
      if ($urandom_range(0, 6) == 0) ifa.hit_lvl = ifa.hit_lvl | 48'($urandom) | 48'($urandom);
      Reset = ($urandom_range(0, 299) == 0);
      @(negedge frame_clk);
      n_tests++;
      if (obs_a() !== pack_m(ma)) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h want %h", cyc, obs_a(), pack_m(ma));
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_and_hits();
    test_same_cycle();
    test_stale_levels();
    test_back_to_back();
    test_reset_mid_play();
    test_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
